// File: rtl/seg_scan_display.sv
// Binary-to-BCD converter feeding a 4-digit multiplexed
// common-anode seven-segment display (decimal or hex).
module seg_scan_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [7:0] value,
  input  logic       hex_mode,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy,
  output logic       conv_done
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  logic [7:0]    last_val;
  logic [7:0]    sh;
  logic [11:0]   bcd;
  logic [11:0]   adj;
  logic [2:0]    cnt;
  logic [3:0]    hund;
  logic [3:0]    tens;
  logic [3:0]    ones;
  logic [7:0]    disp_bin;
  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic [3:0]    dig;
  logic          blank;

  // add-3 correction applied before each shift
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      last_val  <= '0;
      sh        <= '0;
      bcd       <= '0;
      cnt       <= '0;
      hund      <= '0;
      tens      <= '0;
      ones      <= '0;
      disp_bin  <= '0;
      busy      <= 1'b0;
      conv_done <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (value != last_val) begin
            sh       <= value;
            last_val <= value;
            bcd      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, sh} <= {adj, sh} << 1;
          cnt       <= cnt + 3'd1;
          if (cnt == 3'd7) state <= DONE;
        end
        DONE: begin
          hund      <= bcd[11:8];
          tens      <= bcd[7:4];
          ones      <= bcd[3:0];
          disp_bin  <= last_val;
          conv_done <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div <= '0;
      idx <= '0;
    end else if (div == DW'(SCAN_DIV - 1)) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + DW'(1);
    end
  end

  always_comb begin
    dig   = 4'd0;
    blank = 1'b1;
    if (hex_mode) begin
      unique case (idx)
        2'd0: begin
          dig   = disp_bin[3:0];
          blank = 1'b0;
        end
        2'd1: begin
          dig   = disp_bin[7:4];
          blank = 1'b0;
        end
        default: ;
      endcase
    end else begin
      unique case (idx)
        2'd0: begin
          dig   = ones;
          blank = 1'b0;
        end
        2'd1: begin
          dig   = tens;
          blank = (hund == 4'd0) && (tens == 4'd0);
        end
        2'd2: begin
          dig   = hund;
          blank = (hund == 4'd0);
        end
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] d);
    unique case (d)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      seg <= 7'h7F;
      an  <= 4'hF;
    end else begin
      seg <= blank ? 7'h7F : glyph(dig);
      an  <= ~(4'b0001 << idx);
    end
  end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Downstream display stage for the 8-bit up/down counter in the counter_scan design. It takes the counter's `q[7:0]` and converts it to three BCD digits with a sequential 8-step shift-add-3 converter. It then drives a 4-digit, common-anode, time-multiplexed seven-segment display in decimal or hex, with leading-zero blanking. Conversion and scanning run continuously on `clk`, and the displayed digits only change atomically after a complete conversion.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit stays active. Legal range is ≥ 2.
- `clk` (input, 1): system clock. Rising edge only.
- `clr_n` (input, 1): reset. One clock; reset is asynchronous and active-low.
- `value` (input, 8): binary value to display. Connects to the counter's `q`.
- `hex_mode` (input, 1): 1 shows 2-digit hex, 0 shows 3-digit decimal. Takes effect combinationally on digit selection; the output is registered.
- `seg` (output, 7): segments `{g,f,e,d,c,b,a}`, active-low.
- `an` (output, 4): digit enables, active-low, one-hot-low. `an[0]` is the rightmost digit.
- `busy` (output, 1): high while a conversion is in progress.
- `conv_done` (output, 1): one-cycle pulse when the display registers update.

## Operation
- **Converter FSM states:** IDLE, SHIFT, DONE.
- **IDLE:**
  - If `value != last_val`: capture `value` into the shift register, set `last_val <= value`, clear the BCD accumulator, set `cnt <= 0`, `busy <= 1`, go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT:**
  - Each cycle, add 3 to every BCD nibble that is ≥ 5, then shift `{bcd[11:0], sh[7:0]}` left by 1.
  - After 8 shifts (`cnt == 7`), go to DONE.
- **DONE:**
  - Latch `hund`/`tens`/`ones` and `disp_bin <= last_val`.
  - Pulse `conv_done`, set `busy <= 0`, return to IDLE.
- **`value` changes outside IDLE:** ignored while in SHIFT/DONE. IDLE re-compares on the next cycle, so the last stable value is always converted eventually.
- **Ranges:** BCD range is 0–255, so `hund` ≤ 2. There is no overflow path.
- **Scan divider:**
  - `div` counts 0..SCAN_DIV-1 and wraps.
  - On wrap, `idx` (2 bits) advances 0→1→2→3→0.
- **Decimal digit map:**
  - idx0 = `ones`, always shown.
  - idx1 = `tens`, blank if `hund == 0 && tens == 0`.
  - idx2 = `hund`, blank if 0.
  - idx3 = blank.
- **Hex digit map:**
  - idx0 = `disp_bin[3:0]`.
  - idx1 = `disp_bin[7:4]`, always shown, no blanking.
  - idx2 and idx3 = blank.
- **Glyphs (active-low):**
  - Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Hex letters: A=08, b=03, C=46, d=21, E=06, F=0E.
  - Blank = 7F (hex).
- **Outputs:** `an` and `seg` are registered from `idx` and the digit map every cycle. `an = ~(4'b0001 << idx)`.

## Timing
- **Reset values** (while `clr_n` = 0):
  - Outputs: `seg = 7F`, `an = F`, `busy = 0`, `conv_done = 0`.
  - Internal state: FSM = IDLE, `last_val = 0`, `hund`/`tens`/`ones` = 0, `disp_bin = 0`, `div = 0`, `idx = 0`.
- **First edge after release:** `an = 1110`, `seg = 40` (shows "0").
- **Conversion latency:** with the change detected at edge E0, SHIFT occupies E1–E8 and DONE latches at E9. `conv_done` is high for the cycle after E9. `seg` shows the new digit from E10, if that digit is active.
- **Back-to-back changes:** the earliest restart is at E10, giving a minimum of 10 cycles per conversion.
- **Digit dwell:** each digit is active for exactly SCAN_DIV cycles. The full frame is 4×SCAN_DIV.
- **`hex_mode` toggle:** affects `seg` at the next edge. There is no reconversion.
- **`clr_n` asserted mid-conversion:** aborts immediately to the reset values. The old display is not retained.
- **`value` stable after reset:**
  - `value = 0`: no conversion is started.
  - `value ≠ 0`: conversion starts at the first edge.

## Test plan
- **Reset then idle.** Hold `clr_n` low, release with `value = 0`, `SCAN_DIV = 4`. Required: `busy` never rises; digits cycle `an` 1110→1101→1011→0111 every 4 clocks; `seg` is 40 on idx0 and 7F elsewhere.
- **Decimal conversion.** Set `value = 8'd255`. Required: `busy` is high for 9 cycles and `conv_done` pulses at the 10th edge; digits read ones=12, tens=12, hund=24, idx3 = 7F.
- **Leading-zero blanking.** Apply `value = 7`, then `value = 40`:
  - 7: idx1 and idx2 both 7F.
  - 40: idx2 = 7F, idx1 = 19, idx0 = 40.
- **Hex mode.** With `value = 8'hAB`, toggle `hex_mode` to 1. Required: idx0 = 03, idx1 = 08, idx2 and idx3 = 7F; returning to 0 shows 171 as 79/78/79.
- **Change during conversion.** Set `value = 10`, then set `value = 200` 3 cycles later. Required: first conversion completes showing 10; a second `busy` period starts the cycle after DONE; final display is 200 with idx0 = 40, idx1 = 40, idx2 = 24.
- **Reset mid-conversion.** Assert `clr_n` low in SHIFT cycle 4. Required: `busy = 0`, `an = F`, `seg = 7F` asynchronously; after release the display shows the reset value, and the held input `value` is reconverted.
